instr_test_sequencer: RTL and testbench

//  Self-checking instruction sequencer for cpu_top_verify. It replays stored test vectors into the
//  CPU fetch port, one instruction per cycle, then compares a selected register (read port 3)

---
 rtl/instr_test_sequencer_pkg.sv | 26 ++
 rtl/instr_test_sequencer_if.sv | 13 +
 rtl/instr_test_sequencer_vec_mem.sv | 43 ++++
 rtl/instr_test_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instr_test_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_test_sequencer_pkg.sv
// Shared types and constants for the instruction test sequencer: FSM states,
// the RV32 NOP encoding and the layout of the per-test slots in vector memory.
package instr_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CHECK,
        DONE
    } state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    // Each test occupies INSTR_PER_TEST instruction slots followed by these two.
    localparam int SLOT_CHKREG_OFS = 0;  // [4:0] register to read back
    localparam int SLOT_EXP_OFS    = 1;  // expected register value
    localparam int SLOT_EXTRA      = 2;

    // Width helper that never returns 0, so single-entry ranges still get a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_test_sequencer_if.sv
// CPU-facing bus of the sequencer: instruction fetch port plus the register
// read-back port used for the end-of-test compare.
interface instr_test_sequencer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_out;   // instruction presented to the CPU
    logic [XLEN-1:0] imem_addr;  // CPU program counter
    logic [4:0]      ra3;        // check-port register address
    logic [XLEN-1:0] rd3;        // check-port read data

    modport master (output imem_out, output ra3, input imem_addr, input rd3);
    modport slave  (input imem_out, input ra3, output imem_addr, output rd3);
endinterface

// File: rtl/instr_test_sequencer_vec_mem.sv
// Test vector storage: NUM_TESTS*SLOTS words, one synchronous write port and a
// combinational read addressed by {test, slot}. The check-register field of the
// current test is exposed separately because it must stay on ra3 while the main
// read port is busy fetching instructions. Contents are never reset.
module instr_test_vec_mem
    import instr_test_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NUM_TESTS = 8,
    parameter int INSTR_PER_TEST = 3,
    parameter int SLOTS = INSTR_PER_TEST + SLOT_EXTRA,
    parameter int AW    = clog2_min1(NUM_TESTS * SLOTS),
    parameter int TW    = clog2_min1(NUM_TESTS),
    parameter int SW    = clog2_min1(SLOTS)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [TW-1:0]   test_i,
    input  logic [SW-1:0]   slot_i,
    output logic [XLEN-1:0] rdata_o,
    output logic [4:0]      chk_reg_o
);
    localparam int DEPTH = NUM_TESTS * SLOTS;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   chk_idx;

    assign rd_idx    = AW'(int'(test_i) * SLOTS + int'(slot_i));
    assign chk_idx   = AW'(int'(test_i) * SLOTS + INSTR_PER_TEST + SLOT_CHKREG_OFS);
    assign rdata_o   = mem_q[rd_idx];
    assign chk_reg_o = mem_q[chk_idx][4:0];

    // Write port; addresses past the last slot are dropped.
    always_ff @(posedge clk) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_test_sequencer.sv
// Replays stored instruction vectors into a CPU fetch port, one per cycle,
// optionally waits for the CPU pipeline to drain, then compares a selected
// register against the expected value and accumulates pass/fail counts.
// Also checks that the CPU PC advances by 4 per issued instruction.
module instr_test_sequencer
    import instr_test_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int NUM_TESTS      = 8,
    parameter  int INSTR_PER_TEST = 3,
    parameter  int CHECK_DELAY    = 0,
    parameter  int CHECK_PC       = 1,
    localparam int SLOTS = INSTR_PER_TEST + SLOT_EXTRA,
    localparam int AW    = clog2_min1(NUM_TESTS * SLOTS),
    localparam int CW    = $clog2(NUM_TESTS + 1),
    localparam int FW    = clog2_min1(NUM_TESTS),
    localparam int SW    = clog2_min1(SLOTS),
    localparam int DW    = clog2_min1(CHECK_DELAY + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    vec_we_i,
    input  logic [AW-1:0]           vec_addr_i,
    input  logic [XLEN-1:0]         vec_wdata_i,
    instr_test_sequencer_if.master  cpu,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    all_passed_o,
    output logic [CW-1:0]           pass_count_o,
    output logic [CW-1:0]           fail_count_o,
    output logic [FW-1:0]           first_fail_o,
    output logic                    pc_err_o
);
    state_e          state_q;
    logic [FW-1:0]   test_q;
    logic [SW-1:0]   slot_q;
    logic [DW-1:0]   drain_q;
    logic [CW-1:0]   pass_q;
    logic [CW-1:0]   fail_q;
    logic [FW-1:0]   first_fail_q;
    logic            pc_err_q;
    logic [XLEN-1:0] pc_base_q;

    logic            busy;
    logic [SW-1:0]   rd_slot_d;
    logic [XLEN-1:0] vec_word;
    logic [4:0]      chk_reg;
    logic [XLEN-1:0] pc_expect_d;
    logic            pc_bad_d;
    logic            chk_pass_d;
    logic            last_slot;
    logic            last_test;

    assign busy = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == CHECK);

    // The read port fetches instructions during ISSUE and the expected value in CHECK.
    assign rd_slot_d = (state_q == CHECK) ? SW'(INSTR_PER_TEST + SLOT_EXP_OFS) : slot_q;

    instr_test_vec_mem #(
        .XLEN           (XLEN),
        .NUM_TESTS      (NUM_TESTS),
        .INSTR_PER_TEST (INSTR_PER_TEST),
        .SLOTS          (SLOTS),
        .AW             (AW),
        .TW             (FW),
        .SW             (SW)
    ) u_vec_mem (
        .clk       (clk),
        .we_i      (vec_we_i && !busy),
        .waddr_i   (vec_addr_i),
        .wdata_i   (vec_wdata_i),
        .test_i    (test_q),
        .slot_i    (rd_slot_d),
        .rdata_o   (vec_word),
        .chk_reg_o (chk_reg)
    );

    assign cpu.imem_out = (state_q == ISSUE) ? vec_word : XLEN'(RV32_NOP);
    assign cpu.ra3      = (state_q != IDLE) ? chk_reg : 5'd0;

    // 4-state compare: X/Z on rd3 counts as a failure in simulation.
    assign chk_pass_d = (cpu.rd3 === vec_word);

    assign pc_expect_d = pc_base_q + (XLEN'(slot_q) << 2);
    assign pc_bad_d    = (CHECK_PC != 0) && (state_q == ISSUE) && (slot_q != '0)
                         && (cpu.imem_addr != pc_expect_d);

    assign last_slot = (slot_q == SW'(INSTR_PER_TEST - 1));
    assign last_test = (test_q == FW'(NUM_TESTS - 1));

    // Sequencer FSM with its counters, result registers and PC checker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            test_q       <= '0;
            slot_q       <= '0;
            drain_q      <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            first_fail_q <= '0;
            pc_err_q     <= 1'b0;
            pc_base_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q      <= ISSUE;
                        test_q       <= '0;
                        slot_q       <= '0;
                        pass_q       <= '0;
                        fail_q       <= '0;
                        first_fail_q <= '0;
                        pc_err_q     <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (slot_q == '0) begin
                        pc_base_q <= cpu.imem_addr;
                    end
                    if (pc_bad_d) begin
                        pc_err_q <= 1'b1;
                    end
                    if (last_slot) begin
                        slot_q <= '0;
                        if (CHECK_DELAY > 0) begin
                            drain_q <= DW'(CHECK_DELAY - 1);
                            state_q <= DRAIN;
                        end else begin
                            state_q <= CHECK;
                        end
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                CHECK: begin
                    if (chk_pass_d) begin
                        pass_q <= pass_q + 1'b1;
                    end else begin
                        fail_q <= fail_q + 1'b1;
                        if (fail_q == '0) begin
                            first_fail_q <= test_q;
                        end
                    end
                    if (last_test) begin
                        state_q <= DONE;
                    end else begin
                        test_q  <= test_q + 1'b1;
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy;
    assign done_o       = (state_q == DONE);
    assign all_passed_o = (state_q == DONE) && (fail_q == '0) && !pc_err_q;
    assign pass_count_o = pass_q;
    assign fail_count_o = fail_q;
    assign first_fail_o = first_fail_q;
    assign pc_err_o     = pc_err_q;

endmodule

// File: tb/tb_instr_test_sequencer.sv
// Directed bench: two sequencers (no drain / 2-cycle drain) each driving a small
// RV32 ADD/ADDI model CPU with a free-running PC.
module tb_instr_test_sequencer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 0, start1 = 0, we0 = 0, we1 = 0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        busy0, done0, ap0, pce0, busy1, done1, ap1, pce1;
    logic [1:0]  pass0, fail0, ff0, pass1, fail1, ff1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc, nops;
    logic [31:0] vecs [0:14];

    instr_test_sequencer_if #(.XLEN(32)) c0 ();
    instr_test_sequencer_if #(.XLEN(32)) c1 ();

    instr_test_sequencer #(.XLEN(32), .NUM_TESTS(3), .INSTR_PER_TEST(3), .CHECK_DELAY(0), .CHECK_PC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .vec_we_i(we0), .vec_addr_i(waddr),
        .vec_wdata_i(wdata), .cpu(c0), .busy_o(busy0), .done_o(done0), .all_passed_o(ap0),
        .pass_count_o(pass0), .fail_count_o(fail0), .first_fail_o(ff0), .pc_err_o(pce0));

    instr_test_sequencer #(.XLEN(32), .NUM_TESTS(3), .INSTR_PER_TEST(3), .CHECK_DELAY(2), .CHECK_PC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .vec_we_i(we1), .vec_addr_i(waddr),
        .vec_wdata_i(wdata), .cpu(c1), .busy_o(busy1), .done_o(done1), .all_passed_o(ap1),
        .pass_count_o(pass1), .fail_count_o(fail1), .first_fail_o(ff1), .pc_err_o(pce1));

    // Model CPU: ADDI and ADD only.
    function automatic logic is_wr(input logic [31:0] ins);
        return ((ins[6:0] == 7'h13 && ins[14:12] == 3'd0) ||
                (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'd0)) && (ins[11:7] != 5'd0);
    endfunction
    function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        if (ins[6:0] == 7'h13) return r1 + {{20{ins[31]}}, ins[31:20]};
        return r1 + r2;
    endfunction

    logic [31:0] r0 [32] = '{default: 32'd0};
    logic [31:0] a1 [32] = '{default: 32'd0};
    logic [31:0] v1 [32] = '{default: 32'd0};
    logic        pw [2]  = '{default: 1'b0};
    logic [4:0]  prd [2] = '{default: 5'd0};
    logic [31:0] pval [2] = '{default: 32'd0};
    logic [31:0] pc0 = 32'h1000, pc1 = 32'h2000;
    logic        pc_hold = 1'b0;

    always @(posedge clk) begin
        if (is_wr(c0.imem_out))
            r0[c0.imem_out[11:7]] <= alu(c0.imem_out, r0[c0.imem_out[19:15]], r0[c0.imem_out[24:20]]);
        if (!pc_hold) pc0 <= pc0 + 32'd4;
    end

    // Second CPU: architectural state is immediate, the read-back view lags by 2 cycles.
    always @(posedge clk) begin
        if (is_wr(c1.imem_out))
            a1[c1.imem_out[11:7]] <= alu(c1.imem_out, a1[c1.imem_out[19:15]], a1[c1.imem_out[24:20]]);
        pw[0]   <= is_wr(c1.imem_out);
        prd[0]  <= c1.imem_out[11:7];
        pval[0] <= alu(c1.imem_out, a1[c1.imem_out[19:15]], a1[c1.imem_out[24:20]]);
        pw[1]   <= pw[0];
        prd[1]  <= prd[0];
        pval[1] <= pval[0];
        if (pw[1]) v1[prd[1]] <= pval[1];
        pc1 <= pc1 + 32'd4;
    end

    assign c0.imem_addr = pc0;
    assign c0.rd3       = r0[c0.ra3];
    assign c1.imem_addr = pc1;
    assign c1.rd3       = v1[c1.ra3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all();
        for (int i = 0; i < 15; i++) begin
            waddr = 4'(i); wdata = vecs[i]; we0 = 1; we1 = 1;
            tick();
        end
        we0 = 0; we1 = 0;
    endtask

    // mode 1: hold PC0 one edge; mode 2: start+write while busy; mode 3: stop at hook cycle
    task automatic run(input int d, input int hook, input int mode, output int c, output int n);
        if (d == 0) start0 = 1; else start1 = 1;
        tick();
        start0 = 0; start1 = 0; we0 = 0; we1 = 0;
        c = 1; n = 0;
        while (!(d != 0 ? done1 : done0) && c < 200) begin
            if (mode == 3 && c == hook) break;
            if ((d != 0 ? busy1 : busy0) && ((d != 0 ? c1.imem_out : c0.imem_out) == NOP)) n++;
            if (c == hook && mode == 1) pc_hold = 1;
            if (c == hook && mode == 2) begin start0 = 1; we0 = 1; waddr = 4'd9; wdata = 32'd5; end
            tick();
            c++;
            pc_hold = 0; start0 = 0; we0 = 0;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy0 got %b want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done0 got %b want 0", done0); end
        n_cmp++; if (c0.imem_out !== NOP) begin n_bad++; $display("FAIL reset_imem0 got %h want %h", c0.imem_out, NOP); end
        n_cmp++; if (c0.ra3 !== 5'd0) begin n_bad++; $display("FAIL reset_ra3 got %0d want 0", c0.ra3); end
        n_cmp++; if ({pass0, fail0, ff0, pce0, ap0} !== 8'd0) begin n_bad++; $display("FAIL reset_results got %b want 0", {pass0, fail0, ff0, pce0, ap0}); end
        n_cmp++; if (c1.imem_out !== NOP) begin n_bad++; $display("FAIL reset_imem1 got %h want %h", c1.imem_out, NOP); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_all_pass();
        waddr = 4'd14; wdata = 32'd0; we0 = 1;
        tick();
        // write of the real expected value lands in the same cycle as start
        waddr = 4'd14; wdata = 32'hffff_ffff; we0 = 1;
        run(0, 0, 0, cyc, nops);
        n_cmp++; if (cyc != 13) begin n_bad++; $display("FAIL pass_latency got %0d want 13", cyc); end
        n_cmp++; if (pass0 !== 2'd3) begin n_bad++; $display("FAIL pass_count got %0d want 3", pass0); end
        n_cmp++; if (fail0 !== 2'd0) begin n_bad++; $display("FAIL pass_fails got %0d want 0", fail0); end
        n_cmp++; if (ap0 !== 1'b1) begin n_bad++; $display("FAIL pass_all_passed got %b want 1", ap0); end
        n_cmp++; if (c0.ra3 !== 5'd3) begin n_bad++; $display("FAIL pass_ra3 got %0d want 3", c0.ra3); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL pass_busy got %b want 0", busy0); end
    endtask

    task automatic test_fail();
        waddr = 4'd9; wdata = 32'd5; we0 = 1;
        tick();
        we0 = 0;
        run(0, 0, 0, cyc, nops);
        n_cmp++; if (pass0 !== 2'd2) begin n_bad++; $display("FAIL fail_pass got %0d want 2", pass0); end
        n_cmp++; if (fail0 !== 2'd1) begin n_bad++; $display("FAIL fail_count got %0d want 1", fail0); end
        n_cmp++; if (ff0 !== 2'd1) begin n_bad++; $display("FAIL fail_first got %0d want 1", ff0); end
        n_cmp++; if (ap0 !== 1'b0) begin n_bad++; $display("FAIL fail_all_passed got %b want 0", ap0); end
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL fail_done got %b want 1", done0); end
        waddr = 4'd9; wdata = 32'd0; we0 = 1;
        tick();
        we0 = 0;
    endtask

    task automatic test_drain();
        run(1, 0, 0, cyc, nops);
        n_cmp++; if (cyc != 19) begin n_bad++; $display("FAIL drain_latency got %0d want 19", cyc); end
        n_cmp++; if (nops != 9) begin n_bad++; $display("FAIL drain_nop_cycles got %0d want 9", nops); end
        n_cmp++; if (pass1 !== 2'd3) begin n_bad++; $display("FAIL drain_pass got %0d want 3", pass1); end
        n_cmp++; if (ap1 !== 1'b1) begin n_bad++; $display("FAIL drain_all_passed got %b want 1", ap1); end
    endtask

    task automatic test_pc_stall();
        run(0, 1, 1, cyc, nops);
        n_cmp++; if (pce0 !== 1'b1) begin n_bad++; $display("FAIL pc_err got %b want 1", pce0); end
        n_cmp++; if (pass0 !== 2'd3) begin n_bad++; $display("FAIL pc_pass got %0d want 3", pass0); end
        n_cmp++; if (ap0 !== 1'b0) begin n_bad++; $display("FAIL pc_all_passed got %b want 0", ap0); end
        repeat (3) tick();
        n_cmp++; if (pce0 !== 1'b1 || done0 !== 1'b1) begin n_bad++; $display("FAIL pc_err_sticky got %b/%b want 1/1", pce0, done0); end
    endtask

    task automatic test_busy_ignore();
        run(0, 2, 2, cyc, nops);
        n_cmp++; if (cyc != 13) begin n_bad++; $display("FAIL busy_start_latency got %0d want 13", cyc); end
        n_cmp++; if (pass0 !== 2'd3 || fail0 !== 2'd0) begin n_bad++; $display("FAIL busy_counts got %0d/%0d want 3/0", pass0, fail0); end
        n_cmp++; if (ap0 !== 1'b1) begin n_bad++; $display("FAIL busy_all_passed got %b want 1", ap0); end
        run(0, 0, 0, cyc, nops);
        n_cmp++; if (pass0 !== 2'd3 || fail0 !== 2'd0) begin n_bad++; $display("FAIL busy_rerun got %0d/%0d want 3/0", pass0, fail0); end
    endtask

    task automatic test_abort();
        run(1, 10, 3, cyc, nops);
        n_cmp++; if (pass1 !== 2'd1 || busy1 !== 1'b1) begin n_bad++; $display("FAIL abort_pre got pass %0d busy %b want 1/1", pass1, busy1); end
        rst_n = 0;
        #1;
        n_cmp++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL abort_state got busy %b done %b want 0/0", busy1, done1); end
        n_cmp++; if (c1.imem_out !== NOP) begin n_bad++; $display("FAIL abort_imem got %h want %h", c1.imem_out, NOP); end
        n_cmp++; if (pass1 !== 2'd0 || c1.ra3 !== 5'd0) begin n_bad++; $display("FAIL abort_clear got pass %0d ra3 %0d want 0/0", pass1, c1.ra3); end
        #2 rst_n = 1;
        tick();
        run(1, 0, 0, cyc, nops);
        n_cmp++; if (cyc != 19 || pass1 !== 2'd3 || ap1 !== 1'b1) begin n_bad++; $display("FAIL abort_rerun got cyc %0d pass %0d ap %b want 19/3/1", cyc, pass1, ap1); end
    endtask

    initial begin
        vecs = '{32'h00100093, 32'h00208113, 32'h002081b3, 32'd3, 32'd4,
                 32'hfff00093, 32'h00100113, 32'h002081b3, 32'd3, 32'd0,
                 32'h00000093, 32'hfff00113, 32'h002081b3, 32'd3, 32'hffff_ffff};
        test_reset();
        load_all();
        test_all_pass();
        test_fail();
        test_drain();
        test_pc_stall();
        test_busy_ignore();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
